// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types for the unified memory port arbiter:
//   state_t  - arbiter FSM states (IDLE / REQ / WAIT_RSP)
//   owner_t  - which requester owns the port transaction (FE / MEM)
//   payload_w() - width of the latched request payload {we, addr, wdata, be}
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_RSP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_FE  = 1'b0,
      OWN_MEM = 1'b1
   } owner_t;

   // Latched payload layout, MSB first: we, addr, wdata, be
   function automatic int payload_w(input int addr_w, input int data_w);
      return 1 + addr_w + data_w + data_w / 8;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// The single memory port shared by fetch and load/store.
//   req_valid / req_ready  request handshake (arbiter -> memory)
//   we, addr, wdata, be    request payload of the granted requester
//   rsp_valid / rsp_data   response from memory
// Modports: master = arbiter side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  we;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   be;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_data;

   modport master (
      output req_valid, we, addr, wdata, be,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, we, addr, wdata, be,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/mem_arb_grant.sv
// -----------------------------------------------------------------------------
// mem_arb_grant
// IDLE-state arbitration between fetch (FE) and load/store (MEM).
// MEM has priority; after FE_STARVE_MAX consecutive lost arbitrations FE wins.
// A flush blocks any FE grant in the cycle it is asserted.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   in_idle           arbiter FSM is in IDLE (grants only issued then)
//   fe_req_valid      fetch request pending
//   mem_req_valid     load/store request pending
//   flush             fetch redirect
//   grant_fe/mem      one-hot grant for this cycle (combinational)
// -----------------------------------------------------------------------------
module mem_arb_grant #(
   parameter int FE_STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic in_idle,
   input  logic fe_req_valid,
   input  logic mem_req_valid,
   input  logic flush,
   output logic grant_fe,
   output logic grant_mem
);
   localparam int CNT_W = (FE_STARVE_MAX < 1) ? 1 : $clog2(FE_STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(FE_STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt_r;
   logic             fe_ok_s;
   logic             starved_s;

   // Priority decision: starved FE first, then MEM, then FE
   always_comb begin
      fe_ok_s   = fe_req_valid & ~flush;
      starved_s = (starve_cnt_r == STARVE_LIM);
      grant_fe  = 1'b0;
      grant_mem = 1'b0;
      if (in_idle) begin
         if (fe_ok_s && starved_s) begin
            grant_fe = 1'b1;
         end else if (mem_req_valid) begin
            grant_mem = 1'b1;
         end else if (fe_ok_s) begin
            grant_fe = 1'b1;
         end else begin
            grant_fe  = 1'b0;
            grant_mem = 1'b0;
         end
      end else begin
         grant_fe  = 1'b0;
         grant_mem = 1'b0;
      end
   end

   // Count arbitrations FE lost to MEM; any FE grant clears the count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt_r <= '0;
      end else if (grant_fe) begin
         starve_cnt_r <= '0;
      end else if (grant_mem && fe_req_valid && (starve_cnt_r != STARVE_LIM)) begin
         starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between instruction fetch (FE) and load/store (MEM).
// One transaction outstanding at a time: IDLE -> REQ -> WAIT_RSP -> IDLE.
// The owner's rsp_valid pulses one cycle after the memory response.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   fe_req_*/fe_rsp_*/fe_stall       fetch requester
//   flush                            fetch redirect (drops an in-flight fetch)
//   mem_req_*/mem_rsp_*/mem_stall    load/store requester
//   port                             memory port (mem_port_arbiter_if.master)
//   timeout_err                      sticky transaction-timeout flag
// Optional: define MEM_ARB_PERF_EN to add perf_fe_wait / perf_mem_wait,
//   saturating counts of cycles each stall output is high.
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int FE_STARVE_MAX  = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                fe_req_valid,
   input  logic [ADDR_W-1:0]   fe_req_addr,
   output logic                fe_rsp_valid,
   output logic [DATA_W-1:0]   fe_rsp_data,
   output logic                fe_stall,
   input  logic                flush,
   input  logic                mem_req_valid,
   input  logic                mem_req_we,
   input  logic [ADDR_W-1:0]   mem_req_addr,
   input  logic [DATA_W-1:0]   mem_req_wdata,
   input  logic [DATA_W/8-1:0] mem_req_be,
   output logic                mem_rsp_valid,
   output logic [DATA_W-1:0]   mem_rsp_rdata,
   output logic                mem_stall,
   mem_port_arbiter_if.master  port,
   output logic                timeout_err
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]         perf_fe_wait,
   output logic [31:0]         perf_mem_wait
`endif
);
   localparam int PAY_W  = payload_w(ADDR_W, DATA_W);
   localparam int WD_LSB = DATA_W / 8;
   localparam int AD_LSB = WD_LSB + DATA_W;
   localparam int WE_BIT = PAY_W - 1;
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t              state_r;
   owner_t              owner_r;
   logic [PAY_W-1:0]    payload_r;
   logic                port_req_valid_r;
   logic                fe_rsp_valid_r;
   logic                mem_rsp_valid_r;
   logic [DATA_W-1:0]   fe_rsp_data_r;
   logic [DATA_W-1:0]   mem_rsp_data_r;
   logic [TMO_W-1:0]    tmo_cnt_r;
   logic                drop_r;
   logic                timeout_err_r;

   logic                grant_fe_s;
   logic                grant_mem_s;
   logic                busy_s;
   logic                expire_s;
   logic                finish_s;
   logic [DATA_W-1:0]   fin_data_s;
   logic                drop_s;

   mem_arb_grant #(.FE_STARVE_MAX(FE_STARVE_MAX)) u_grant (
      .clk           (clk),
      .reset         (reset),
      .in_idle       (state_r == ST_IDLE),
      .fe_req_valid  (fe_req_valid),
      .mem_req_valid (mem_req_valid),
      .flush         (flush),
      .grant_fe      (grant_fe_s),
      .grant_mem     (grant_mem_s)
   );

   // Transaction completion: timeout beats both ready and response
   always_comb begin
      busy_s     = (state_r == ST_REQ) || (state_r == ST_WAIT_RSP);
      expire_s   = busy_s && (tmo_cnt_r == TMO_LAST);
      drop_s     = drop_r | (flush & (owner_r == OWN_FE));
      finish_s   = 1'b0;
      fin_data_s = '0;
      if (expire_s) begin
         finish_s   = 1'b1;
         fin_data_s = '0;
      end else if ((state_r == ST_WAIT_RSP) && port.rsp_valid) begin
         finish_s   = 1'b1;
         fin_data_s = port.rsp_data;
      end else begin
         finish_s   = 1'b0;
         fin_data_s = '0;
      end
   end

   // Arbiter FSM with registered port request and response outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r          <= ST_IDLE;
         owner_r          <= OWN_FE;
         payload_r        <= '0;
         port_req_valid_r <= 1'b0;
         fe_rsp_valid_r   <= 1'b0;
         mem_rsp_valid_r  <= 1'b0;
         fe_rsp_data_r    <= '0;
         mem_rsp_data_r   <= '0;
         tmo_cnt_r        <= '0;
         drop_r           <= 1'b0;
         timeout_err_r    <= 1'b0;
      end else begin
         fe_rsp_valid_r  <= 1'b0;
         mem_rsp_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               tmo_cnt_r <= '0;
               drop_r    <= 1'b0;
               if (grant_mem_s) begin
                  owner_r          <= OWN_MEM;
                  payload_r        <= {mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be};
                  port_req_valid_r <= 1'b1;
                  state_r          <= ST_REQ;
               end else if (grant_fe_s) begin
                  owner_r          <= OWN_FE;
                  payload_r        <= {1'b0, fe_req_addr, {DATA_W{1'b0}}, {(DATA_W/8){1'b0}}};
                  port_req_valid_r <= 1'b1;
                  state_r          <= ST_REQ;
               end
            end
            ST_REQ, ST_WAIT_RSP: begin
               tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
               drop_r    <= drop_s;
               if (finish_s) begin
                  state_r          <= ST_IDLE;
                  port_req_valid_r <= 1'b0;
                  if (expire_s) begin
                     timeout_err_r <= 1'b1;
                  end
                  if (owner_r == OWN_MEM) begin
                     mem_rsp_valid_r <= 1'b1;
                     mem_rsp_data_r  <= fin_data_s;
                  end else if (!drop_s) begin
                     fe_rsp_valid_r  <= 1'b1;
                     fe_rsp_data_r   <= fin_data_s;
                  end
               end else if ((state_r == ST_REQ) && port.req_ready) begin
                  state_r          <= ST_WAIT_RSP;
                  port_req_valid_r <= 1'b0;
               end
            end
            default: begin
               state_r          <= ST_IDLE;
               port_req_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign port.req_valid = port_req_valid_r;
   assign port.we        = payload_r[WE_BIT];
   assign port.addr      = payload_r[WE_BIT-1:AD_LSB];
   assign port.wdata     = payload_r[AD_LSB-1:WD_LSB];
   assign port.be        = payload_r[WD_LSB-1:0];

   assign fe_rsp_valid  = fe_rsp_valid_r;
   assign fe_rsp_data   = fe_rsp_data_r;
   assign mem_rsp_valid = mem_rsp_valid_r;
   assign mem_rsp_rdata = mem_rsp_data_r;
   assign timeout_err   = timeout_err_r;
   assign fe_stall      = fe_req_valid  & ~fe_rsp_valid_r;
   assign mem_stall     = mem_req_valid & ~mem_rsp_valid_r;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_fe_r;
   logic [31:0] perf_mem_r;

   // Saturating stall-cycle counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fe_r  <= 32'd0;
         perf_mem_r <= 32'd0;
      end else begin
         if (fe_stall && (perf_fe_r != 32'hFFFF_FFFF)) begin
            perf_fe_r <= perf_fe_r + 32'd1;
         end
         if (mem_stall && (perf_mem_r != 32'hFFFF_FFFF)) begin
            perf_mem_r <= perf_mem_r + 32'd1;
         end
      end
   end

   assign perf_fe_wait  = perf_fe_r;
   assign perf_mem_wait = perf_mem_r;
`endif
endmodule
